// File: rtl/mem_arbiter.sv
// Memory arbiter: serializes icache fetches and dcache loads/stores onto one RAM port.
// Optional instruction-starvation guard is compiled in with MEMARB_STARVE_GUARD_EN.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module mem_arbiter
`ifdef MEMARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      iREN,
    input  logic [31:0]               iaddr,
    output logic                      iwait,
    output logic [31:0]               iload,
    input  logic                      dREN,
    input  logic                      dWEN,
    input  logic [31:0]               daddr,
    input  logic [31:0]               dstore,
    output logic                      dwait,
    output logic [31:0]               dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  cpu_types_pkg::ramstate_t  ramstate
);
    import cpu_types_pkg::*;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] INSTR = 2'd2;

    logic [1:0]  state, next_state;
    logic [31:0] lat_addr, lat_store;
    logic        lat_wr;
    logic        grant_d, grant_i;
    logic        starve_pick;
    logic        i_abort;
    logic        ram_done;

    // A fetch is abandoned as soon as the icache withdraws or redirects.
    assign i_abort  = !iREN || (iaddr != lat_addr);
    assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign starve_pick = iREN && (starve_cnt >= CW'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && iREN && (starve_cnt < CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_pick = 1'b0;
`endif

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                if (starve_pick)        grant_i = 1'b1;
                else if (dREN || dWEN)  grant_d = 1'b1;
                else if (iREN)          grant_i = 1'b1;
                if (grant_d)            next_state = DATA;
                else if (grant_i)       next_state = INSTR;
            end
            DATA: begin
                if (ram_done) next_state = IDLE;
            end
            INSTR: begin
                if (i_abort || ram_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DATA: begin
                ramaddr  = lat_addr;
                ramstore = lat_store;
                ramREN   = !lat_wr;
                ramWEN   = lat_wr;
                if (ramstate == ACCESS) begin
                    dwait = 1'b0;
                    dload = lat_wr ? 32'd0 : ramload;
                end
            end
            INSTR: begin
                if (!i_abort) begin
                    ramREN  = 1'b1;
                    ramaddr = lat_addr;
                    if (ramstate == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wr    <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_wr    <= dWEN;
            end else if (grant_i) begin
                lat_addr  <= iaddr;
                lat_store <= '0;
                lat_wr    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload = '0;
    ramstate_t   ramstate = FREE;

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the transaction currently owning the RAM (0 none, 1 data, 2 fetch).
    localparam int LIMIT = 4;
    int          m_kind = 0, n_kind;
    logic [31:0] m_addr = '0, m_store = '0, n_addr, n_store;
    bit          m_wr = 1'b0, n_wr;
    int          m_starve = 0, n_starve;
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    bit          live, fin;

    initial begin
        forever begin
            @(negedge CLK);
            e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
            e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
            n_kind = m_kind; n_addr = m_addr; n_store = m_store; n_wr = m_wr; n_starve = m_starve;
            fin = (ramstate == ACCESS) || (ramstate == ERROR);
            if (!nRST) begin
                n_kind = 0; n_addr = 0; n_store = 0; n_wr = 0; n_starve = 0;
            end else if (m_kind == 1) begin
                e_addr = m_addr; e_store = m_store; e_ren = !m_wr; e_wen = m_wr;
                if (ramstate == ACCESS) begin
                    e_dwait = 0;
                    e_dload = m_wr ? 32'd0 : ramload;
                end
                if (fin) n_kind = 0;
            end else if (m_kind == 2) begin
                live = iREN && (iaddr == m_addr);
                if (live) begin
                    e_ren = 1; e_addr = m_addr;
                    if (ramstate == ACCESS) begin
                        e_iwait = 0; e_iload = ramload;
                    end
                end
                if (!live || fin) n_kind = 0;
            end else begin
`ifdef MEMARB_STARVE_GUARD_EN
                if (iREN && m_starve >= LIMIT) begin
                    n_kind = 2; n_addr = iaddr; n_store = 0; n_wr = 0; n_starve = 0;
                end else
`endif
                if (dREN || dWEN) begin
                    n_kind = 1; n_addr = daddr; n_store = dstore; n_wr = dWEN;
                    if (iREN && m_starve < LIMIT) n_starve = m_starve + 1;
                end else if (iREN) begin
                    n_kind = 2; n_addr = iaddr; n_store = 0; n_wr = 0; n_starve = 0;
                end
            end
            chk("m_iwait", iwait, e_iwait);
            chk("m_iload", iload, e_iload);
            chk("m_dwait", dwait, e_dwait);
            chk("m_dload", dload, e_dload);
            chk("m_ramREN", ramREN, e_ren);
            chk("m_ramWEN", ramWEN, e_wen);
            chk("m_ramaddr", ramaddr, e_addr);
            chk("m_ramstore", ramstore, e_store);
            chk("one_wait_low", 32'(!iwait && !dwait), 0);
            @(posedge CLK);
            if (!nRST) begin
                m_kind = 0; m_addr = 0; m_store = 0; m_wr = 0; m_starve = 0;
            end else begin
                m_kind = n_kind; m_addr = n_addr; m_store = n_store; m_wr = n_wr; m_starve = n_starve;
            end
        end
    end

    task automatic set_in(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                          input logic [31:0] da, input logic [31:0] ds,
                          input ramstate_t r, input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = r; ramload = rl;
        #3;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_in(0, 0, 0, 0, 0, 0, FREE, 0);
            tick();
        end
    endtask

    int dpulse, ipulse, first_i;

    initial begin
        #3;
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        tick();
        nRST = 1'b1;
        idle(2);

        // Fetch only, two BUSY cycles then ACCESS
        set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        chk("f_idle_ren", ramREN, 0);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        chk("f_busy_ren", ramREN, 1);
        chk("f_busy_addr", ramaddr, 32'h40);
        chk("f_busy_iwait", iwait, 1);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        chk("f_busy2_iwait", iwait, 1);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C220004);
        chk("f_acc_iwait", iwait, 0);
        chk("f_acc_iload", iload, 32'h8C220004);
        tick();
        set_in(0, 32'h40, 0, 0, 0, 0, FREE, 32'h8C220004);
        chk("f_after_iwait", iwait, 1);
        chk("f_after_iload", iload, 0);
        chk("f_after_ren", ramREN, 0);
        tick();
        idle(1);

        // Simultaneous: data wins, fetch follows
        set_in(1, 32'h40, 1, 0, 32'h100, 0, FREE, 0);
        tick();
        set_in(1, 32'h40, 1, 0, 32'h100, 0, ACCESS, 32'h11111111);
        chk("s_d_addr", ramaddr, 32'h100);
        chk("s_dwait", dwait, 0);
        chk("s_dload", dload, 32'h11111111);
        chk("s_iwait", iwait, 1);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        chk("s_gap_ren", ramREN, 0);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h22222222);
        chk("s_i_addr", ramaddr, 32'h40);
        chk("s_i_iwait", iwait, 0);
        chk("s_i_iload", iload, 32'h22222222);
        tick();
        idle(2);

        // Store, with later input change ignored
        set_in(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, FREE, 0);
        tick();
        set_in(0, 0, 0, 1, 32'h999, 32'h0, BUSY, 0);
        chk("w_wen", ramWEN, 1);
        chk("w_ren", ramREN, 0);
        chk("w_addr", ramaddr, 32'h200);
        chk("w_store", ramstore, 32'hDEADBEEF);
        chk("w_busy_dwait", dwait, 1);
        tick();
        set_in(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, ACCESS, 32'h55555555);
        chk("w_dwait", dwait, 0);
        chk("w_dload", dload, 0);
        tick();
        idle(2);

        // Fetch abort on redirect, then refetch
        set_in(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        tick();
        set_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        chk("a_ren", ramREN, 1);
        tick();
        set_in(1, 32'h80, 0, 0, 0, 0, BUSY, 0);
        chk("a_drop_ren", ramREN, 0);
        chk("a_drop_iwait", iwait, 1);
        tick();
        set_in(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h33333333);
        chk("a_idle_iwait", iwait, 1);
        tick();
        set_in(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'h33333333);
        chk("a_re_addr", ramaddr, 32'h80);
        chk("a_re_iload", iload, 32'h33333333);
        tick();
        idle(2);

        // ERROR drops back to IDLE, request re-arbitrated
        set_in(0, 0, 1, 0, 32'h300, 0, FREE, 0);
        tick();
        set_in(0, 0, 1, 0, 32'h300, 0, ERROR, 32'h44444444);
        chk("e_dwait", dwait, 1);
        tick();
        set_in(0, 0, 1, 0, 32'h300, 0, FREE, 0);
        chk("e_idle_ren", ramREN, 0);
        tick();
        set_in(0, 0, 1, 0, 32'h300, 0, ACCESS, 32'h44444444);
        chk("e_retry_dload", dload, 32'h44444444);
        tick();
        idle(2);

        // Reset asserted mid-DATA
        set_in(0, 0, 1, 0, 32'h400, 0, FREE, 0);
        tick();
        set_in(0, 0, 1, 0, 32'h400, 0, BUSY, 0);
        chk("r_ren", ramREN, 1);
        tick();
        nRST = 1'b0;
        set_in(0, 0, 1, 0, 32'h400, 0, BUSY, 0);
        chk("r_ren_drop", ramREN, 0);
        chk("r_addr", ramaddr, 0);
        chk("r_dwait", dwait, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, ACCESS, 32'h66666666);
        tick();
        nRST = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, ACCESS, 32'h66666666);
        chk("r_post_dwait", dwait, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, ACCESS, 32'h66666666);
        chk("r_post2_dwait", dwait, 1);
        tick();
        idle(2);

        // Continuous data requests with a fetch held
        dpulse = 0; ipulse = 0; first_i = -1;
        for (int c = 0; c < 12; c++) begin
            set_in(1, 32'h500, 1, 0, 32'h600, 0, ACCESS, 32'hA0 + c);
            if (!dwait) dpulse++;
            if (!iwait) begin
                ipulse++;
                if (first_i < 0) first_i = c;
            end
            tick();
        end
`ifdef MEMARB_STARVE_GUARD_EN
        chk("st_dpulses", dpulse, 5);
        chk("st_ipulses", ipulse, 1);
        chk("st_first_i", first_i, 9);
`else
        chk("st_dpulses", dpulse, 6);
        chk("st_ipulses", ipulse, 0);
`endif
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
